// File: rtl/me_pkg.sv
// Shared widths and state encoding for the motion-estimation search controller.
// Build option ME_SEARCH_CYCLE_CNT_EN is consumed by me_search_ctrl.
package me_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int pos_f(input int tb_len, input int sw_len);
    return sw_len - tb_len + 1;
  endfunction

  function automatic int ncand_f(input int tb_len, input int sw_len);
    return pos_f(tb_len, sw_len) * pos_f(tb_len, sw_len);
  endfunction

  function automatic int cnt_width_f(input int tb_len, input int sw_len);
    return $clog2(ncand_f(tb_len, sw_len));
  endfunction

  function automatic int pos_width_f(input int tb_len, input int sw_len);
    return $clog2(pos_f(tb_len, sw_len));
  endfunction

  function automatic int sad_width_f(input int tb_len, input int pe_w);
    return $clog2(tb_len * tb_len) + pe_w;
  endfunction

endpackage

// File: rtl/me_min_tracker.sv
// Working-minimum register for the full search; strict-less update so ties
// keep the earliest tag. best_* shows the minimum including this cycle's strobe.
module me_min_tracker
  import me_pkg::*;
#(
  parameter int SAD_WIDTH = 10,
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 RSTN,
  input  logic                 clr,
  input  logic                 strobe,
  input  logic [SAD_WIDTH-1:0] sad_in,
  input  logic [TAG_WIDTH-1:0] tag,
  output logic [SAD_WIDTH-1:0] best_sad,
  output logic [TAG_WIDTH-1:0] best_tag
);

  logic                 have;
  logic                 load;
  logic [SAD_WIDTH-1:0] min_sad;
  logic [TAG_WIDTH-1:0] min_tag;

  assign load     = strobe && (!have || (sad_in < min_sad));
  assign best_sad = load ? sad_in : min_sad;
  assign best_tag = load ? tag : min_tag;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      have    <= 1'b0;
      min_sad <= '0;
      min_tag <= '0;
    end else if (clr) begin
      have    <= 1'b0;
      min_sad <= '0;
      min_tag <= '0;
    end else if (load) begin
      have    <= 1'b1;
      min_sad <= sad_in;
      min_tag <= tag;
    end
  end

endmodule

// File: rtl/me_search_ctrl.sv
// Full-search ME controller: raster issue, in-order SAD return, min tracking,
// req/ack four-phase handshake. ME_SEARCH_CYCLE_CNT_EN adds search_cycles.
module me_search_ctrl
  import me_pkg::*;
#(
  parameter int TB_LENGTH    = 16,
  parameter int SW_LENGTH    = 64,
  parameter int PE_OUT_WIDTH = 8,
  localparam int POS       = pos_f(TB_LENGTH, SW_LENGTH),
  localparam int NCAND     = ncand_f(TB_LENGTH, SW_LENGTH),
  localparam int CNT_WIDTH = cnt_width_f(TB_LENGTH, SW_LENGTH),
  localparam int POS_WIDTH = pos_width_f(TB_LENGTH, SW_LENGTH),
  localparam int SAD_WIDTH = sad_width_f(TB_LENGTH, PE_OUT_WIDTH)
) (
  input  logic                   clk,
  input  logic                   RSTN,
  input  logic                   req,
  output logic                   cand_valid,
  output logic [POS_WIDTH-1:0]   cand_x,
  output logic [POS_WIDTH-1:0]   cand_y,
  input  logic                   sad_valid,
  input  logic [SAD_WIDTH-1:0]   sad_in,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   min_cnt,
  output logic [SAD_WIDTH-1:0]   min_sad,
  output logic [2*POS_WIDTH-1:0] min_mvec,
`ifdef ME_SEARCH_CYCLE_CNT_EN
  output logic [31:0]            search_cycles,
`endif
  output logic                   ack
);

  localparam int TAG_WIDTH = CNT_WIDTH + 2 * POS_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NCAND - 1);
  localparam logic [POS_WIDTH-1:0] LAST_POS = POS_WIDTH'(POS - 1);

  state_t               state;
  logic [POS_WIDTH-1:0] ix, iy, rx, ry;
  logic [CNT_WIDTH-1:0] icnt, rcnt;
  logic                 issue_done;
  logic                 start, issue, ret, done_now;
  logic [SAD_WIDTH-1:0] best_sad;
  logic [TAG_WIDTH-1:0] best_tag;

  assign start    = (state == IDLE) && req;
  assign issue    = (state == RUN) && !issue_done;
  assign ret      = (state == RUN) && sad_valid;
  // abort wins over completion when req falls on the final return
  assign done_now = ret && req && (rcnt == LAST_CNT);

  assign cand_valid = issue;
  assign cand_x     = ix;
  assign cand_y     = iy;
  assign busy       = (state == RUN);
  assign ack        = (state == DONE);

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state <= RUN;
        RUN: begin
          if (!req)          state <= IDLE;
          else if (done_now) state <= DONE;
        end
        DONE:    if (!req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      ix         <= '0;
      iy         <= '0;
      icnt       <= '0;
      issue_done <= 1'b0;
    end else if (start) begin
      ix         <= '0;
      iy         <= '0;
      icnt       <= '0;
      issue_done <= 1'b0;
    end else if (issue) begin
      if (icnt == LAST_CNT) begin
        issue_done <= 1'b1;
      end else begin
        icnt <= icnt + CNT_WIDTH'(1);
        if (ix == LAST_POS) begin
          ix <= '0;
          iy <= iy + POS_WIDTH'(1);
        end else begin
          ix <= ix + POS_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      rx   <= '0;
      ry   <= '0;
      rcnt <= '0;
    end else if (start) begin
      rx   <= '0;
      ry   <= '0;
      rcnt <= '0;
    end else if (ret && (rcnt != LAST_CNT)) begin
      rcnt <= rcnt + CNT_WIDTH'(1);
      if (rx == LAST_POS) begin
        rx <= '0;
        ry <= ry + POS_WIDTH'(1);
      end else begin
        rx <= rx + POS_WIDTH'(1);
      end
    end
  end

  me_min_tracker #(
    .SAD_WIDTH(SAD_WIDTH),
    .TAG_WIDTH(TAG_WIDTH)
  ) u_min (
    .clk     (clk),
    .RSTN    (RSTN),
    .clr     (start),
    .strobe  (ret),
    .sad_in  (sad_in),
    .tag     ({rcnt, ry, rx}),
    .best_sad(best_sad),
    .best_tag(best_tag)
  );

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      min_cnt  <= '0;
      min_sad  <= '0;
      min_mvec <= '0;
    end else if (done_now) begin
      min_sad             <= best_sad;
      {min_cnt, min_mvec} <= best_tag;
    end
  end

`ifdef ME_SEARCH_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      search_cycles <= '0;
    end else if (start) begin
      search_cycles <= '0;
    end else if ((state == RUN) && (search_cycles != '1)) begin
      search_cycles <= search_cycles + 32'd1;
    end
  end
`endif

endmodule
